// File: rtl/rca_pkg.sv
// Shared types and constants for the sequenced ripple-carry adder controller.
`timescale 1ns/1ps
package rca_pkg;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StAdd  = 2'd1,
    StDone = 2'd2
  } rca_state_e;

  localparam int unsigned NIBBLE_W = 4;

  function automatic int unsigned num_steps(input int unsigned width);
    return width / NIBBLE_W;
  endfunction

endpackage

// File: rtl/rca_seq_ctrl_slice.sv
// 4-bit ripple-carry adder slice; with RCA_SEQ_OVF_EN it also exposes the carry into bit 3.
`timescale 1ns/1ps
module rca_seq_ctrl_slice (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       c_in,
  output logic [3:0] s,
  output logic       c_out
`ifdef RCA_SEQ_OVF_EN
  ,
  output logic       c_msb
`endif
);

  logic [4:0] c;

  always_comb begin
    c    = '0;
    s    = '0;
    c[0] = c_in;
    for (int i = 0; i < 4; i++) begin
      s[i]   = a[i] ^ b[i] ^ c[i];
      c[i+1] = (a[i] & b[i]) | (a[i] & c[i]) | (b[i] & c[i]);
    end
  end

  assign c_out = c[4];
`ifdef RCA_SEQ_OVF_EN
  assign c_msb = c[3];
`endif

endmodule

// File: rtl/rca_seq_ctrl.sv
// Wide adder that walks one shared 4-bit slice over the operands, LSB nibble first.
// Optional signed-overflow output enabled by defining RCA_SEQ_OVF_EN.
`timescale 1ns/1ps
module rca_seq_ctrl
  import rca_pkg::*;
#(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_valid,
  output logic             start_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             c_in,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [WIDTH-1:0] sum,
  output logic             c_out,
  output logic             busy
`ifdef RCA_SEQ_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int unsigned N    = num_steps(WIDTH);
  localparam int unsigned IdxW = $clog2(N);

  if ((WIDTH % NIBBLE_W) != 0 || WIDTH < 8) begin : g_bad_width
    $error("rca_seq_ctrl: WIDTH must be a multiple of 4 and at least 8");
  end

  rca_state_e       state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d, sum_q, sum_d;
  logic [IdxW-1:0]  idx_q, idx_d;
  logic             carry_q, carry_d, c_out_q, c_out_d;

  logic [3:0] slice_a, slice_b, slice_s;
  logic       slice_co;
  logic       last_step;

  assign slice_a   = a_q[NIBBLE_W*int'(idx_q) +: NIBBLE_W];
  assign slice_b   = b_q[NIBBLE_W*int'(idx_q) +: NIBBLE_W];
  assign last_step = (idx_q == IdxW'(N - 1));

`ifdef RCA_SEQ_OVF_EN
  logic slice_c_msb;
  logic ovf_q, ovf_d;

  rca_seq_ctrl_slice u_slice (
    .a     (slice_a),
    .b     (slice_b),
    .c_in  (carry_q),
    .s     (slice_s),
    .c_out (slice_co),
    .c_msb (slice_c_msb)
  );
`else
  rca_seq_ctrl_slice u_slice (
    .a     (slice_a),
    .b     (slice_b),
    .c_in  (carry_q),
    .s     (slice_s),
    .c_out (slice_co)
  );
`endif

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    sum_d   = sum_q;
    idx_d   = idx_q;
    carry_d = carry_q;
    c_out_d = c_out_q;
`ifdef RCA_SEQ_OVF_EN
    ovf_d   = ovf_q;
`endif
    unique case (state_q)
      StIdle: begin
        if (start_valid) begin
          a_d     = a;
          b_d     = b;
          carry_d = c_in;
          idx_d   = '0;
          sum_d   = '0;
          state_d = StAdd;
        end
      end
      StAdd: begin
        sum_d[NIBBLE_W*int'(idx_q) +: NIBBLE_W] = slice_s;
        carry_d = slice_co;
        if (last_step) begin
          c_out_d = slice_co;
`ifdef RCA_SEQ_OVF_EN
          // Signed overflow: carry into the MSB disagrees with carry out of it.
          ovf_d   = slice_c_msb ^ slice_co;
`endif
          idx_d   = '0;
          state_d = StDone;
        end else begin
          idx_d = idx_q + IdxW'(1);
        end
      end
      StDone: begin
        if (res_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      idx_q   <= '0;
      carry_q <= 1'b0;
      c_out_q <= 1'b0;
`ifdef RCA_SEQ_OVF_EN
      ovf_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sum_q   <= sum_d;
      idx_q   <= idx_d;
      carry_q <= carry_d;
      c_out_q <= c_out_d;
`ifdef RCA_SEQ_OVF_EN
      ovf_q   <= ovf_d;
`endif
    end
  end

  assign start_ready = (state_q == StIdle);
  assign res_valid   = (state_q == StDone);
  assign busy        = (state_q != StIdle);
  assign sum         = sum_q;
  assign c_out       = c_out_q;
`ifdef RCA_SEQ_OVF_EN
  assign ovf         = ovf_q;
`endif

endmodule

// File: tb/tb_rca_seq_ctrl.sv
// Directed self-checking bench for rca_seq_ctrl (WIDTH=16).
`timescale 1ns/1ps
module tb_rca_seq_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start_valid;
  logic        start_ready;
  logic [15:0] a, b;
  logic        c_in;
  logic        res_valid;
  logic        res_ready;
  logic [15:0] sum;
  logic        c_out;
  logic        busy;
`ifdef RCA_SEQ_OVF_EN
  logic        ovf;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  rca_seq_ctrl #(
    .WIDTH (16)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start_valid (start_valid),
    .start_ready (start_ready),
    .a           (a),
    .b           (b),
    .c_in        (c_in),
    .res_valid   (res_valid),
    .res_ready   (res_ready),
    .sum         (sum),
    .c_out       (c_out),
    .busy        (busy)
`ifdef RCA_SEQ_OVF_EN
    ,
    .ovf         (ovf)
`endif
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // One operation; hold = cycles res_ready stays low in DONE; poke drives start during ADD/DONE.
  task automatic run_op(input string tag, input logic [15:0] av, input logic [15:0] bv,
                        input logic cv, input int hold, input bit poke,
                        input logic [15:0] exp_sum, input logic exp_co, input logic exp_ovf);
    int edges;
    @(negedge clk);
    res_ready   = (hold == 0);
    a           = av;
    b           = bv;
    c_in        = cv;
    start_valid = 1'b1;
    check_eq({tag, "_start_ready"}, 32'(start_ready), 32'd1);
    @(posedge clk);
    @(negedge clk);
    a    = ~av;
    b    = ~bv;
    c_in = ~cv;
    if (!poke) start_valid = 1'b0;
    check_eq({tag, "_busy"}, 32'(busy), 32'd1);
    edges = 0;
    while (!res_valid && edges < 20) begin
      if (poke) check_eq({tag, "_ready_in_add"}, 32'(start_ready), 32'd0);
      @(posedge clk);
      edges++;
      @(negedge clk);
    end
    check_eq({tag, "_latency"}, 32'(edges), 32'd4);
    check_eq({tag, "_sum"}, 32'(sum), 32'(exp_sum));
    check_eq({tag, "_c_out"}, 32'(c_out), 32'(exp_co));
`ifdef RCA_SEQ_OVF_EN
    check_eq({tag, "_ovf"}, 32'(ovf), 32'(exp_ovf));
`else
    if (exp_ovf === 1'bx) n_checks = n_checks;
`endif
    for (int i = 0; i < hold; i++) begin
      @(posedge clk);
      @(negedge clk);
      check_eq({tag, "_hold_valid"}, 32'(res_valid), 32'd1);
      check_eq({tag, "_hold_sum"}, 32'(sum), 32'(exp_sum));
      if (poke) check_eq({tag, "_ready_in_done"}, 32'(start_ready), 32'd0);
    end
    start_valid = 1'b0;
    res_ready   = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check_eq({tag, "_idle_valid"}, 32'(res_valid), 32'd0);
    check_eq({tag, "_idle_ready"}, 32'(start_ready), 32'd1);
    check_eq({tag, "_idle_sum"}, 32'(sum), 32'(exp_sum));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int cycles;
    rst_n       = 1'b0;
    start_valid = 1'b0;
    res_ready   = 1'b1;
    a           = '0;
    b           = '0;
    c_in        = 1'b0;
    #23;
    check_eq("rst_start_ready", 32'(start_ready), 32'd1);
    check_eq("rst_res_valid", 32'(res_valid), 32'd0);
    check_eq("rst_busy", 32'(busy), 32'd0);
    check_eq("rst_sum", 32'(sum), 32'd0);
    check_eq("rst_c_out", 32'(c_out), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    run_op("cin",    16'h0000, 16'h0002, 1'b1, 0, 1'b0, 16'h0003, 1'b0, 1'b0);
    run_op("chain",  16'h0FFF, 16'h0001, 1'b0, 0, 1'b0, 16'h1000, 1'b0, 1'b0);
    run_op("wrap",   16'hFFFF, 16'h0001, 1'b0, 0, 1'b0, 16'h0000, 1'b1, 1'b0);
    run_op("sovf",   16'h7FFF, 16'h0001, 1'b0, 0, 1'b0, 16'h8000, 1'b0, 1'b1);
    run_op("negovf", 16'h8000, 16'h8000, 1'b1, 0, 1'b0, 16'h0001, 1'b1, 1'b1);
    run_op("hold",   16'h1234, 16'h4321, 1'b0, 3, 1'b1, 16'h5555, 1'b0, 1'b0);

    // Abort on the second ADD edge: partial sum 0x00AA must vanish.
    @(negedge clk);
    a = 16'h9999; b = 16'h1111; c_in = 1'b0; start_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start_valid = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    check_eq("abort_sum", 32'(sum), 32'd0);
    check_eq("abort_busy", 32'(busy), 32'd0);
    check_eq("abort_res_valid", 32'(res_valid), 32'd0);
    check_eq("abort_c_out", 32'(c_out), 32'd0);
    check_eq("abort_start_ready", 32'(start_ready), 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check_eq("after_abort_ready", 32'(start_ready), 32'd1);
    run_op("post", 16'h0008, 16'h0008, 1'b0, 0, 1'b0, 16'h0010, 1'b0, 1'b0);

    // Back-to-back with res_ready high: second accept N+2 = 6 edges after the first.
    @(negedge clk);
    res_ready = 1'b1;
    a = 16'h00FF; b = 16'h0F01; c_in = 1'b0; start_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    a = 16'hA5A5; b = 16'h5A5B; c_in = 1'b0;
    cycles = 0;
    while (!start_ready && cycles < 20) begin
      if (res_valid) begin
        check_eq("b2b_first_sum", 32'(sum), 32'h1000);
        check_eq("b2b_first_c_out", 32'(c_out), 32'd0);
      end
      @(posedge clk);
      cycles++;
      @(negedge clk);
    end
    check_eq("b2b_spacing", 32'(cycles + 1), 32'd6);
    @(posedge clk);
    @(negedge clk);
    start_valid = 1'b0;
    cycles = 0;
    while (!res_valid && cycles < 20) begin
      @(posedge clk);
      cycles++;
      @(negedge clk);
    end
    check_eq("b2b_second_latency", 32'(cycles), 32'd4);
    check_eq("b2b_second_sum", 32'(sum), 32'h0000);
    check_eq("b2b_second_c_out", 32'(c_out), 32'd1);
    @(posedge clk);
    @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
